// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM encoding for the UART transmit path
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int UART_FRAME_TICKS = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered level/full/empty and flush
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   input  logic             flush,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [LW-1:0]    level,
   output logic             full,
   output logic             empty,
   output logic             wr_drop
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_acc;
   logic             rd_acc;

   // full is the registered flag, so a same-cycle pop cannot rescue a write
   assign wr_acc  = wr_en && !full_q && !flush;
   assign rd_acc  = rd_en && !empty_q && !flush;
   assign wr_drop = wr_en && full_q && !flush;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         level_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + 1'b1;
         if (rd_acc) rptr_d = rptr_q + 1'b1;
         if (wr_acc && !rd_acc) begin
            level_d = level_q + 1'b1;
         end else if (!wr_acc && rd_acc) begin
            level_d = level_q - 1'b1;
         end
      end
      full_d  = (level_d == LW'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rptr_q];
   assign level   = level_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue feeding uart_transmitter, paced by baud ticks
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int FRAME_TICKS = UART_FRAME_TICKS,
   parameter int GAP_TICKS   = 1,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   baud_clk_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   wr_en,
   input  logic                   flush,
   output logic [UART_DATA_W-1:0] tx_data,
   output logic                   tx_start_send,
   output logic                   full,
   output logic                   empty,
   output logic [LW-1:0]          level,
   output logic                   busy,
   output logic                   overflow
);

   localparam int TOTAL_TICKS = FRAME_TICKS + GAP_TICKS;
   localparam int CW          = $clog2(TOTAL_TICKS + 1);

   uart_state_e            state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   overflow_q;
   logic                   pop;
   logic [UART_DATA_W-1:0] fifo_rd_data;
   logic                   fifo_empty;
   logic                   fifo_wr_drop;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_data (wr_data),
      .wr_en   (wr_en),
      .flush   (flush),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .level   (level),
      .full    (full),
      .empty   (fifo_empty),
      .wr_drop (fifo_wr_drop)
   );

   // The transmitter has no busy flag, so frame end is inferred from tick count
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty && !flush) begin
               pop        = 1'b1;
               tx_data_d  = fifo_rd_data;
               tx_start_d = 1'b1;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (baud_clk_en) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(TOTAL_TICKS - 1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overflow_q <= fifo_wr_drop;
      end
   end

   assign tx_data       = tx_data_q;
   assign tx_start_send = tx_start_q;
   assign empty         = fifo_empty;
   assign busy          = (state_q != ST_IDLE);
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - scoreboard bench for uart_tx_queue
module tb_uart_tx_queue;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_clk_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start_send;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       busy;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   uart_tx_queue #(
      .DEPTH       (16),
      .FRAME_TICKS (10),
      .GAP_TICKS   (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .baud_clk_en   (baud_clk_en),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .flush         (flush),
      .tx_data       (tx_data),
      .tx_start_send (tx_start_send),
      .full          (full),
      .empty         (empty),
      .level         (level),
      .busy          (busy),
      .overflow      (overflow)
   );

   typedef struct {
      logic [7:0] data;
      int         lvl;
      bit         chk_gap;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         cyc = 0;
   int         starts = 0;
   int         pushed = 0;
   int         ovf_cnt = 0;
   int         tick_cnt = 0;
   int         fall_cyc = 0;
   logic [7:0] cur_byte = 8'h00;
   bit         busy_prev = 1'b0;
   bit         tick_chk = 1'b1;
   bit         baud_run = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string nm, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(logic [7:0] d, int lvl, bit gap);
      exp_t x;
      x.data    = d;
      x.lvl     = lvl;
      x.chk_gap = gap;
      sb.push_back(x);
      pushed++;
   endtask

   task automatic write_byte(logic [7:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(int max, string nm);
      int n = 0;
      @(negedge clk);
      while (!(busy === 1'b0 && empty === 1'b1) && n < max) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_drained"}, {30'd0, busy, empty}, 32'd1);
      step();
   endtask

   // baud tick: one cycle in sixteen, driven just after the clock edge
   initial begin
      int div = 0;
      forever begin
         @(posedge clk);
         #1;
         if (baud_run) begin
            div = (div == 15) ? 0 : div + 1;
            baud_clk_en = (div == 15);
         end else begin
            div = 0;
            baud_clk_en = 1'b0;
         end
      end
   end

   // monitor: compares each start pulse against the scoreboard, tracks frame ticks
   always @(negedge clk) begin
      if (tx_start_send === 1'b1) begin
         starts++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_start: tx_data=%0h, nothing expected", tx_data);
         end else begin
            e = sb.pop_front();
            check("start_data", tx_data, e.data);
            if (e.lvl >= 0) check("start_level", level, e.lvl);
            if (e.chk_gap) check("b2b_gap", cyc - fall_cyc, 1);
         end
         cur_byte = tx_data;
         tick_cnt = 0;
      end else if (busy === 1'b1) begin
         check("tx_data_hold", tx_data, cur_byte);
         if (baud_clk_en === 1'b1) tick_cnt++;
      end
      if (busy_prev && busy === 1'b0) begin
         fall_cyc = cyc;
         if (tick_chk) check("frame_ticks", tick_cnt, 11);
      end
      if (overflow === 1'b1) ovf_cnt++;
      busy_prev = (busy === 1'b1);
   end

   initial begin
      int s0;
      int o0;

      // reset and idle
      rst_n = 1'b0;
      step();
      @(negedge clk);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_start", tx_start_send, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_level", level, 0);
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      step();
      rst_n = 1'b1;
      repeat (100) step();
      @(negedge clk);
      check("idle_starts", starts, 0);
      check("idle_tx_data", tx_data, 8'h00);
      check("idle_empty", empty, 1'b1);
      check("idle_busy", busy, 1'b0);

      // single byte latency
      baud_run = 1'b1;
      step();
      expect_byte(8'h41, -1, 1'b0);
      write_byte(8'h41);
      @(negedge clk);
      check("lat_n1_start", tx_start_send, 1'b0);
      check("lat_n1_level", level, 1);
      @(negedge clk);
      check("lat_n2_start", tx_start_send, 1'b1);
      check("lat_n2_data", tx_data, 8'h41);
      @(negedge clk);
      check("lat_n3_start", tx_start_send, 1'b0);
      check("lat_n3_busy", busy, 1'b1);
      wait_drain(400, "single");

      // back-to-back burst
      expect_byte(8'h10, 1, 1'b0);
      expect_byte(8'h11, 2, 1'b1);
      expect_byte(8'h12, 1, 1'b1);
      expect_byte(8'h13, 0, 1'b1);
      for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i));
      @(negedge clk);
      check("burst_level", level, 3);
      wait_drain(1500, "burst");

      // overflow with the FSM parked in WAIT
      baud_run = 1'b0;
      step();
      expect_byte(8'hA0, -1, 1'b0);
      write_byte(8'hA0);
      step();
      step();
      o0 = ovf_cnt;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) expect_byte(8'h20 + 8'(i), -1, 1'b0);
         write_byte(8'h20 + 8'(i));
      end
      @(negedge clk);
      check("ovf_level", level, 16);
      check("ovf_full", full, 1'b1);
      check("ovf_pulse", overflow, 1'b1);
      step();
      step();
      check("ovf_count", ovf_cnt - o0, 1);
      check("ovf_level_hold", level, 16);
      baud_run = 1'b1;
      wait_drain(4000, "ovf");

      // flush during a frame
      expect_byte(8'h50, -1, 1'b0);
      for (int i = 0; i < 5; i++) write_byte(8'h50 + 8'(i));
      repeat (20) step();
      s0 = starts;
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      check("flush_level", level, 0);
      check("flush_empty", empty, 1'b1);
      check("flush_busy", busy, 1'b1);
      check("flush_tx_data", tx_data, 8'h50);
      wait_drain(400, "flush");
      repeat (100) step();
      check("flush_no_start", starts - s0, 0);

      // reset mid-frame
      expect_byte(8'h60, -1, 1'b0);
      for (int i = 0; i < 4; i++) write_byte(8'h60 + 8'(i));
      repeat (20) step();
      @(negedge clk);
      check("prerst_level", level, 3);
      check("prerst_busy", busy, 1'b1);
      step();
      s0 = starts;
      tick_chk = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_busy", busy, 1'b0);
      check("midrst_level", level, 0);
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_empty", empty, 1'b1);
      step();
      tick_chk = 1'b1;
      repeat (200) step();
      check("midrst_no_start", starts - s0, 0);

      check("sb_empty", sb.size(), 0);
      check("start_total", starts, pushed);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
